// File: rtl/sat_pkg.sv
// Shared types for the BCP datapath: implication record and round-sequencing states.
package sat_pkg;

  localparam int MAX_VAR_COUNT = 512;
  localparam int VAR_W         = 9;

  typedef struct packed {
    logic [VAR_W-1:0] var_idx;
    logic             val;
  } imply_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    CONFLICT = 2'd2
  } bcp_state_e;

endpackage

// File: rtl/implication_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: search starts at i_ptr and wraps, first requester wins.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_gnt_idx
);

  logic w_found;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!w_found && i_req[(int'(i_ptr) + k) % N]) begin
        o_gnt[(int'(i_ptr) + k) % N] = 1'b1;
        o_gnt_idx                    = W'((int'(i_ptr) + k) % N);
        w_found                      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/implication_arbiter.sv
// Serialises evaluator implications into the conflict detector, one per cycle,
// and sequences a BCP round to either a done pulse or a held conflict report.
//   state    | meaning
//   IDLE     | waiting for start, no grants
//   RUN      | granting and issuing implications, watching for conflict/fixpoint
//   CONFLICT | conflict reported, waiting for conflict_ack
module implication_arbiter #(
  parameter int NUM_EVAL = 4,
  parameter int VAR_W    = 9,
  parameter int CNT_W    = 10
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NUM_EVAL-1:0]       i_req_valid,
  input  logic [NUM_EVAL*VAR_W-1:0] i_req_var,
  input  logic [NUM_EVAL-1:0]       i_req_val,
  output logic [NUM_EVAL-1:0]       o_req_ready,
  input  logic [NUM_EVAL-1:0]       i_eval_busy,
  output logic                      o_det_en,
  output logic [VAR_W-1:0]          o_det_var,
  output logic                      o_det_val,
  input  logic                      i_det_conflict,
  output logic                      o_bcp_done,
  output logic                      o_bcp_conflict,
  output logic [VAR_W-1:0]          o_conflict_var,
  input  logic                      i_conflict_ack,
  output logic [CNT_W-1:0]          o_imply_count
);

  import sat_pkg::*;

  localparam int IDX_W = $clog2(NUM_EVAL);

  bcp_state_e        r_state;
  logic [IDX_W-1:0]  r_rr_ptr;
  logic              r_det_en;
  logic [VAR_W-1:0]  r_det_var;
  logic              r_det_val;
  logic              r_done;
  logic              r_conflict;
  logic [VAR_W-1:0]  r_conflict_var;
  logic [CNT_W-1:0]  r_count;

  logic [NUM_EVAL-1:0] w_gnt;
  logic [IDX_W-1:0]    w_gnt_idx;
  logic                w_grant_en;
  logic                w_take;
  logic [IDX_W-1:0]    w_next_ptr;
  logic [VAR_W-1:0]    w_sel_var;
  logic                w_fixpoint;

  rr_arbiter #(.N(NUM_EVAL), .W(IDX_W)) u_rr_arbiter (
    .i_req     (i_req_valid),
    .i_ptr     (r_rr_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Holding ready low while the detector flags a conflict means nothing is accepted and then lost.
  assign w_grant_en  = (r_state == RUN) && !i_det_conflict;
  assign o_req_ready = w_gnt & {NUM_EVAL{w_grant_en}};
  assign w_take      = |o_req_ready;
  assign w_next_ptr  = (w_gnt_idx == IDX_W'(NUM_EVAL - 1)) ? '0 : w_gnt_idx + 1'b1;
  assign w_sel_var   = i_req_var[w_gnt_idx*VAR_W +: VAR_W];
  assign w_fixpoint  = !(|i_req_valid) && !(|i_eval_busy) && !r_det_en;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state        <= IDLE;
      r_rr_ptr       <= '0;
      r_det_en       <= 1'b0;
      r_det_var      <= '0;
      r_det_val      <= 1'b0;
      r_done         <= 1'b0;
      r_conflict     <= 1'b0;
      r_conflict_var <= '0;
      r_count        <= '0;
    end else begin
      r_done   <= 1'b0;
      r_det_en <= 1'b0;
      if (w_take) begin
        r_det_en  <= 1'b1;
        r_det_var <= w_sel_var;
        r_det_val <= i_req_val[w_gnt_idx];
        r_rr_ptr  <= w_next_ptr;
      end
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_state <= RUN;
            r_count <= '0;
          end
        end
        RUN: begin
          if (r_det_en && i_det_conflict) begin
            r_state        <= CONFLICT;
            r_conflict     <= 1'b1;
            r_conflict_var <= r_det_var;
          end else begin
            if (r_det_en && (r_count != '1)) r_count <= r_count + 1'b1;
            if (w_fixpoint) begin
              r_done  <= 1'b1;
              r_state <= IDLE;
            end
          end
        end
        CONFLICT: begin
          if (i_conflict_ack) begin
            r_state    <= IDLE;
            r_conflict <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_det_en       = r_det_en;
  assign o_det_var      = r_det_var;
  assign o_det_val      = r_det_val;
  assign o_bcp_done     = r_done;
  assign o_bcp_conflict = r_conflict;
  assign o_conflict_var = r_conflict_var;
  assign o_imply_count  = r_count;

endmodule

// File: tb/tb_implication_arbiter.sv
// Directed bench for implication_arbiter; a second instance with a 2-bit counter shares the stimulus.
module tb_implication_arbiter;

  logic        clk;
  logic        rst;
  logic        start;
  logic [3:0]  req_valid;
  logic [35:0] req_var;
  logic [3:0]  req_val;
  logic [3:0]  eval_busy;
  logic        det_conflict;
  logic        ack;

  logic [3:0]  ready,    ready_b;
  logic        det_en,   det_en_b;
  logic [8:0]  det_var,  det_var_b;
  logic        det_val,  det_val_b;
  logic        done,     done_b;
  logic        conf,     conf_b;
  logic [8:0]  cvar,     cvar_b;
  logic [9:0]  count;
  logic [1:0]  count_b;

  int n_checks = 0;
  int n_errors = 0;

  implication_arbiter #(.NUM_EVAL(4), .VAR_W(9), .CNT_W(10)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_req_valid(req_valid), .i_req_var(req_var), .i_req_val(req_val),
    .o_req_ready(ready), .i_eval_busy(eval_busy),
    .o_det_en(det_en), .o_det_var(det_var), .o_det_val(det_val),
    .i_det_conflict(det_conflict), .o_bcp_done(done), .o_bcp_conflict(conf),
    .o_conflict_var(cvar), .i_conflict_ack(ack), .o_imply_count(count)
  );

  implication_arbiter #(.NUM_EVAL(4), .VAR_W(9), .CNT_W(2)) dut_sat (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .i_req_valid(req_valid), .i_req_var(req_var), .i_req_val(req_val),
    .o_req_ready(ready_b), .i_eval_busy(eval_busy),
    .o_det_en(det_en_b), .o_det_var(det_var_b), .o_det_val(det_val_b),
    .i_det_conflict(det_conflict), .o_bcp_done(done_b), .o_bcp_conflict(conf_b),
    .o_conflict_var(cvar_b), .i_conflict_ack(ack), .o_imply_count(count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; req_valid = '0; req_var = '0; req_val = '0;
    eval_busy = '0; det_conflict = 1'b0; ack = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_det_en", det_en, 0);
    chk("rst_det_var", det_var, 0);
    chk("rst_det_val", det_val, 0);
    chk("rst_done", done, 0);
    chk("rst_conflict", conf, 0);
    chk("rst_cvar", cvar, 0);
    chk("rst_count", count, 0);

    // single implication, then fixpoint
    start = 1'b1;
    tick();
    start = 1'b0;
    req_valid = 4'b0001; req_var[0 +: 9] = 9'd5; req_val = 4'b0001;
    #1 chk("t1_ready", ready, 4'b0001);
    tick();
    req_valid = '0;
    chk("t1_det_en", det_en, 1);
    chk("t1_det_var", det_var, 5);
    chk("t1_det_val", det_val, 1);
    tick();
    chk("t1_det_en_low", det_en, 0);
    chk("t1_count", count, 1);
    chk("t1_done_early", done, 0);
    tick();
    chk("t1_done", done, 1);
    tick();
    chk("t1_done_pulse", done, 0);
    req_valid = 4'b0001;
    #1 chk("t1_idle_ready", ready, 0);
    req_valid = '0;

    // all four requesting: rotation 0,1,2,3,0 back-to-back; start in RUN ignored
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    req_valid = 4'b1111; req_val = 4'b0101;
    for (int i = 0; i < 4; i++) req_var[i*9 +: 9] = 9'(10 + i);
    for (int k = 0; k < 5; k++) begin
      #1 chk($sformatf("t2_ready_%0d", k), ready, 4'b0001 << (k % 4));
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
      chk($sformatf("t2_det_en_%0d", k), det_en, 1);
      chk($sformatf("t2_det_var_%0d", k), det_var, 10 + (k % 4));
      chk($sformatf("t2_det_val_%0d", k), det_val, ((k % 2) == 0) ? 1 : 0);
    end
    req_valid = '0;
    tick();
    chk("t2_count", count, 5);
    chk("t2_count_sat", count_b, 3);
    chk("t2_det_en_off", det_en, 0);
    tick();
    chk("t2_done", done, 1);

    // same variable implied both ways: conflict reported and held until ack
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    eval_busy = 4'b0001;
    req_valid = 4'b0001; req_var[0 +: 9] = 9'd7; req_val = 4'b0001;
    tick();
    chk("t3_det_var_a", det_var, 7);
    chk("t3_det_val_a", det_val, 1);
    req_val = 4'b0000;
    #1 chk("t3_ready_b", ready, 4'b0001);
    tick();
    chk("t3_det_val_b", det_val, 0);
    det_conflict = 1'b1;
    req_valid = 4'b0010; req_var[9 +: 9] = 9'd20;
    #1 chk("t3_ready_conflict_cycle", ready, 0);
    tick();
    det_conflict = 1'b0;
    chk("t3_conflict", conf, 1);
    chk("t3_cvar", cvar, 7);
    chk("t3_det_en", det_en, 0);
    chk("t3_count", count, 1);
    #1 chk("t3_ready_held", ready, 0);
    tick();
    chk("t3_conflict_held", conf, 1);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t3_conflict_clear", conf, 0);
    #1 chk("t3_idle_ready", ready, 0);
    req_valid = '0; eval_busy = '0;

    // conflict coincides with an otherwise empty fixpoint
    do_reset();
    start = 1'b1;
    tick();
    start = 1'b0;
    req_valid = 4'b0001; req_var[0 +: 9] = 9'd3; req_val = 4'b0000;
    tick();
    req_valid = '0;
    det_conflict = 1'b1;
    tick();
    det_conflict = 1'b0;
    chk("t4_conflict", conf, 1);
    chk("t4_done", done, 0);
    chk("t4_cvar", cvar, 3);
    tick();
    chk("t4_done_later", done, 0);
    ack = 1'b1;
    tick();
    ack = 1'b0;
    chk("t4_conflict_clear", conf, 0);

    // reset mid-round with three pending requests (no reset beforehand: conflict_var is 3)
    start = 1'b1;
    tick();
    start = 1'b0;
    eval_busy = 4'b0111;
    req_valid = 4'b0111; req_val = 4'b0111;
    for (int i = 0; i < 3; i++) req_var[i*9 +: 9] = 9'(30 + i);
    tick();
    chk("t5_det_en_pre", det_en, 1);
    chk("t5_det_var_pre", det_var, 31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_det_en", det_en, 0);
    chk("t5_det_var", det_var, 0);
    chk("t5_det_val", det_val, 0);
    chk("t5_cvar", cvar, 0);
    chk("t5_count", count, 0);
    chk("t5_done", done, 0);
    #1 chk("t5_ready", ready, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("t5_no_issue_%0d", k), det_en, 0);
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("t5_restart_issue", det_en, 1);
    chk("t5_restart_var", det_var, 30);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
